// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared definitions for icache_sa_param. Holds the FSM state
//             encoding, the address-field width helpers and the tree-PLRU
//             update/victim functions (up to 8 ways, 7 node bits).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package icache_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_lookup = 2'd1;
    localparam logic [1:0] c_st_miss   = 2'd2;
    localparam logic [1:0] c_st_refill = 2'd3;

    // Byte-offset width of a line: word select plus the two byte bits.
    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned sets,
                                          input int unsigned line_words);
        return addr_w - idx_w(sets) - off_w(line_words);
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    // A node bit of 0 means "victim is on the left". On an access every
    // node on the path is turned to point away from the accessed way.
    function automatic logic [6:0] plru_update(input logic [6:0]  bits,
                                               input int unsigned lvls,
                                               input logic [2:0]  way);
        logic [6:0]  res;
        logic [2:0]  path;
        int unsigned node;
        logic        dir;
        res  = bits;
        path = way << (3 - lvls);
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < int'(lvls)) begin
                dir            = path[2];
                res[node[2:0]] = ~dir;
                node           = 2 * node + 1 + {31'd0, dir};
                path           = {path[1:0], 1'b0};
            end
        end
        return res;
    endfunction

    // Follow the node bits from the root; the path spells the victim way.
    function automatic logic [2:0] plru_victim(input logic [6:0]  bits,
                                               input int unsigned lvls);
        logic [2:0]  vic;
        int unsigned node;
        logic        dir;
        vic  = '0;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < int'(lvls)) begin
                dir  = bits[node[2:0]];
                vic  = {vic[1:0], dir};
                node = 2 * node + 1 + {31'd0, dir};
            end
        end
        return vic;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_way_ram.sv
`default_nettype none
// ============================================================================
//  Module   : icache_way_ram
//  Purpose  : One cache way: synchronous-read, synchronous-write RAM holding
//             {tag, line data} per set. No reset; validity is tracked by
//             flops in the parent.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module icache_way_ram #(
    parameter int unsigned SETS   = 256,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned DATA_W = 275
) (
    input  logic              clk,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [SETS];
    logic [DATA_W-1:0] r_rdata;

    // Single-cycle registered read, independent write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/icache_sa_param.sv
`default_nettype none
// ============================================================================
//  Module   : icache_sa_param
//  Purpose  : N-way set-associative read-only instruction cache with
//             valid/ready fetch handshake, tree-PLRU replacement and per-set
//             invalidate. Optional ICACHE_PERF_CNT_EN adds saturating
//             hit/miss counters.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module icache_sa_param
    import icache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 256,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_W     = 32,
    localparam int unsigned IDX_W     = idx_w(SETS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic [ADDR_W-1:0]        cpu_addr,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [31:0]              cpu_rdata,
    input  logic                     inv_req,
    input  logic [IDX_W-1:0]         inv_index,
    output logic                     inv_done,
    output logic                     mem_rd_req,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic                     mem_rd_ack,
    input  logic                     mem_rd_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rd_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]              perf_hit_cnt,
    output logic [31:0]              perf_miss_cnt
`endif
);

    localparam int unsigned OFF_W  = off_w(LINE_WORDS);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int unsigned LINE_W = 32 * LINE_WORDS;
    localparam int unsigned RAM_W  = TAG_W + LINE_W;
    localparam int unsigned LVLS   = $clog2(WAYS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? LVLS : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_inv_done;
    logic [SETS-1:0]   r_valid [WAYS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [OFF_W-3:0]  w_word;
    logic              w_accept;
    logic              w_refill;
    logic [RAM_W-1:0]  w_rd_line [WAYS];
    logic [WAYS-1:0]   w_hit_vec;
    logic [WAYS-1:0]   w_we_vec;
    logic              w_hit;
    logic [31:0]       w_hit_word;
    logic [31:0]       w_fill_word;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_victim;
    logic [WAY_W-1:0]  w_plru_victim;
    logic              w_unused;

    assign w_idx       = r_addr[OFF_W +: IDX_W];
    assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word      = r_addr[OFF_W-1:2];
    assign w_accept    = (r_state == c_st_idle) && !inv_req && cpu_req;
    assign w_refill    = (r_state == c_st_refill) && mem_rd_valid;
    assign w_hit       = |w_hit_vec;
    assign w_fill_word = mem_rd_data[{w_word, 5'd0} +: 32];
    assign w_unused    = ^{cpu_addr[1:0], r_addr[1:0]};

    // One RAM per way; tag compare against the registered lookup address
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_way_ram #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .DATA_W (RAM_W)
        ) u_ram (
            .clk     (clk),
            .i_re    (w_accept),
            .i_raddr (cpu_addr[OFF_W +: IDX_W]),
            .i_we    (w_we_vec[g]),
            .i_waddr (w_idx),
            .i_wdata ({w_tag, mem_rd_data}),
            .o_rdata (w_rd_line[g])
        );
        assign w_we_vec[g]  = w_refill && (w_victim == WAY_W'(g));
        assign w_hit_vec[g] = r_valid[g][w_idx] &&
                              (w_rd_line[g][RAM_W-1 -: TAG_W] == w_tag);
    end

    // Select the hit way's word; at most one way matches
    always_comb begin
        w_hit_word = '0;
        w_hit_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_vec[w]) begin
                w_hit_word = w_hit_word | w_rd_line[w][{w_word, 5'd0} +: 32];
                w_hit_way  = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the PLRU choice
    always_comb begin
        w_victim = w_plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    if (WAYS > 1) begin : g_plru
        logic [PLRU_W-1:0] r_plru [SETS];
        logic [6:0]        w_bits_rd;
        logic [6:0]        w_bits_upd;
        logic [2:0]        w_vict3;
        logic [2:0]        w_upd3;
        logic              w_plru_unused;

        // Widen the set's PLRU bits and compute victim / updated tree
        always_comb begin
            w_bits_rd               = '0;
            w_bits_rd[PLRU_W-1:0]   = r_plru[w_idx];
            w_vict3                 = plru_victim(w_bits_rd, LVLS);
            w_upd3                  = '0;
            w_upd3[WAY_W-1:0]       = (r_state == c_st_lookup) ? w_hit_way : w_victim;
            w_bits_upd              = plru_update(w_bits_rd, LVLS, w_upd3);
        end

        assign w_plru_victim = w_vict3[WAY_W-1:0];
        assign w_plru_unused = ^{w_bits_upd, w_vict3};

        // PLRU state: cleared by reset or invalidate, touched on hit/refill
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < SETS; s++) begin
                    r_plru[s] <= '0;
                end
            end else if ((r_state == c_st_idle) && inv_req) begin
                r_plru[inv_index] <= '0;
            end else if (((r_state == c_st_lookup) && w_hit) || w_refill) begin
                r_plru[w_idx] <= w_bits_upd[PLRU_W-1:0];
            end
        end
    end else begin : g_no_plru
        assign w_plru_victim = '0;
    end

    // Main control FSM, valid bits and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_inv_done <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else begin
            r_rvalid   <= 1'b0;
            r_inv_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (inv_req) begin
                        for (int w = 0; w < WAYS; w++) begin
                            r_valid[w][inv_index] <= 1'b0;
                        end
                        r_inv_done <= 1'b1;
                    end else if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_state <= c_st_lookup;
                    end
                end
                c_st_lookup: begin
                    if (w_hit) begin
                        r_rdata  <= w_hit_word;
                        r_rvalid <= 1'b1;
                        r_state  <= c_st_idle;
                    end else begin
                        r_state  <= c_st_miss;
                    end
                end
                c_st_miss: begin
                    if (mem_rd_ack) begin
                        r_state <= c_st_refill;
                    end
                end
                c_st_refill: begin
                    if (mem_rd_valid) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (w_we_vec[w]) begin
                                r_valid[w][w_idx] <= 1'b1;
                            end
                        end
                        r_rdata  <= w_fill_word;
                        r_rvalid <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating lookup outcome counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == c_st_lookup) begin
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else if (!w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign perf_hit_cnt  = r_hit_cnt;
    assign perf_miss_cnt = r_miss_cnt;
`endif

    assign cpu_ready   = (r_state == c_st_idle);
    assign cpu_rvalid  = r_rvalid;
    assign cpu_rdata   = r_rdata;
    assign inv_done    = r_inv_done;
    assign mem_rd_req  = (r_state == c_st_miss);
    assign mem_rd_addr = (r_state == c_st_miss) ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;

    a_single_hit: assert property (@(posedge clk) disable iff (reset)
                                   (r_state == c_st_lookup) |-> $onehot0(w_hit_vec));

endmodule
`default_nettype wire

// File: tb/tb_icache_sa_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_sa_param
//  Purpose  : Self-checking bench for icache_sa_param (2 ways, 256 sets,
//             8-word lines) with a scoreboard of expected fetch data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_sa_param;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         cpu_ready;
    logic         cpu_rvalid;
    logic [31:0]  cpu_rdata;
    logic         inv_req;
    logic [7:0]   inv_index;
    logic         inv_done;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_ack;
    logic         mem_rd_valid;
    logic [255:0] mem_rd_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  perf_hit_cnt;
    logic [31:0]  perf_miss_cnt;
`endif

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] sb_q [$];

    localparam logic [31:0] c_a = 32'h1000_00A0;
    localparam logic [31:0] c_b = 32'h2000_00A0;
    localparam logic [31:0] c_c = 32'h3000_00A0;
    localparam logic [31:0] c_x = 32'h4000_0048;

    icache_sa_param #(
        .WAYS       (2),
        .SETS       (256),
        .LINE_WORDS (8),
        .ADDR_W     (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_ready    (cpu_ready),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .inv_req      (inv_req),
        .inv_index    (inv_index),
        .inv_done     (inv_done),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt (perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Backing-memory model: line 0x1C00_0000 holds 0x100+i, others a hash
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] la;
        logic [2:0]  wi;
        la = {addr[31:5], 5'd0};
        wi = addr[4:2];
        if (la == 32'h1C00_0000) return 32'h100 + {29'd0, wi};
        return (la + {27'd0, wi, 2'b00}) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] addr);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[32*i +: 32] = mem_word({addr[31:5], i[2:0], 2'b00});
        end
        return l;
    endfunction

    // Issue one fetch from a negedge, serve the memory side, check the response
    task automatic fetch(input logic [31:0] addr, input bit exp_miss, input int ack_dly,
                         input bit with_inv, input string nm);
        bit          saw_req = 0;
        bit          acked   = 0;
        bit          sent    = 0;
        bit          got     = 0;
        int          acnt    = 0;
        int          lat     = 0;
        logic [31:0] exp_d;
        n_cmp++;
        if (cpu_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL %s ready: got %b want 1", nm, cpu_ready);
        end
        cpu_addr = addr;
        cpu_req  = 1'b1;
        if (with_inv) begin
            inv_req   = 1'b1;
            inv_index = addr[12:5];
            @(negedge clk);
            n_cmp++;
            if (inv_done !== 1'b1 || cpu_rvalid !== 1'b0) begin
                n_mis++;
                $display("FAIL %s inv_done: got %b rvalid %b want 1/0", nm, inv_done, cpu_rvalid);
            end
            inv_req = 1'b0;
        end
        sb_q.push_back(mem_word(addr));
        @(posedge clk);
        #1 cpu_req = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (mem_rd_valid) mem_rd_valid = 1'b0;
            if (cpu_rvalid) begin
                got = 1;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL %s rvalid with empty scoreboard", nm);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (cpu_rdata !== exp_d) begin
                        n_mis++;
                        $display("FAIL %s rdata: got %h want %h", nm, cpu_rdata, exp_d);
                    end
                end
            end else if (mem_rd_ack) begin
                mem_rd_ack = 1'b0;
                acked      = 1;
            end else if (mem_rd_req && !acked) begin
                if (!saw_req) begin
                    saw_req = 1;
                    n_cmp++;
                    if (mem_rd_addr !== {addr[31:5], 5'd0}) begin
                        n_mis++;
                        $display("FAIL %s mem_rd_addr: got %h want %h", nm, mem_rd_addr,
                                 {addr[31:5], 5'd0});
                    end
                end
                if (acnt == ack_dly) mem_rd_ack = 1'b1;
                else                 acnt++;
            end else if (acked && !sent) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mk_line(addr);
                sent         = 1;
            end
        end
        n_cmp++;
        if (!got) begin
            n_mis++;
            $display("FAIL %s timeout: no cpu_rvalid within 40 cycles", nm);
            sb_q.delete();
        end
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        n_cmp++;
        if (saw_req != exp_miss) begin
            n_mis++;
            $display("FAIL %s miss: got %0d want %0d", nm, saw_req, exp_miss);
        end
        if (!exp_miss) begin
            n_cmp++;
            if (lat != 2) begin
                n_mis++;
                $display("FAIL %s hit_latency: got %0d want 2", nm, lat);
            end
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        n_cmp++;
        if (cpu_ready !== 1'b1 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0 ||
            inv_done !== 1'b0 || mem_rd_req !== 1'b0 || mem_rd_addr !== 32'd0) begin
            n_mis++;
            $display("FAIL %s outputs: ready %b rvalid %b rdata %h inv_done %b req %b addr %h want 1 0 0 0 0 0",
                     nm, cpu_ready, cpu_rvalid, cpu_rdata, inv_done, mem_rd_req, mem_rd_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_asserted");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_cold_miss();
        fetch(32'h1C00_0004, 1'b1, 2, 1'b0, "cold_miss");
    endtask

    task automatic test_hit();
        fetch(32'h1C00_001C, 1'b0, 0, 1'b0, "hit_after_refill");
`ifdef ICACHE_PERF_CNT_EN
        n_cmp++;
        if (perf_miss_cnt !== 32'd1 || perf_hit_cnt !== 32'd1) begin
            n_mis++;
            $display("FAIL perf_cnt: got hit %0d miss %0d want 1 1", perf_hit_cnt, perf_miss_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            fetch(32'h1C00_0000 + 32'(4 * i), 1'b0, 0, 1'b0, "b2b_hit");
        end
    endtask

    task automatic test_replacement();
        fetch(c_a, 1'b1, 0, 1'b0, "repl_A_fill");
        fetch(c_b, 1'b1, 1, 1'b0, "repl_B_fill");
        fetch(c_c, 1'b1, 0, 1'b0, "repl_C_evicts_A");
        fetch(c_b, 1'b0, 0, 1'b0, "repl_B_hit");
        fetch(c_a, 1'b1, 0, 1'b0, "repl_A_remiss");
        fetch(c_b, 1'b0, 0, 1'b0, "repl_B_still_hit");
    endtask

    task automatic test_invalidate();
        fetch(c_a, 1'b1, 0, 1'b1, "inv_then_A_miss");
        fetch(c_b, 1'b1, 0, 1'b0, "inv_B_miss");
        fetch(c_a, 1'b0, 0, 1'b0, "inv_A_hit");
    endtask

    task automatic test_reset_refill();
        bit seen = 0;
        cpu_addr = c_x;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_rd_req) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_mis++;
            $display("FAIL rst_refill mem_rd_req: got 0 want 1");
        end
        mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        reset      = 1'b1;
        #1;
        check_idle_outputs("rst_in_refill");
        @(negedge clk);
        reset        = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = mk_line(c_x);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        check_idle_outputs("late_valid_ignored");
        fetch(c_x, 1'b1, 0, 1'b0, "post_rst_X_miss");
        fetch(c_b, 1'b1, 0, 1'b0, "post_rst_B_miss");
    endtask

    initial begin
        reset        = 1'b1;
        cpu_req      = 1'b0;
        cpu_addr     = '0;
        inv_req      = 1'b0;
        inv_index    = '0;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_replacement();
        test_invalidate();
        test_reset_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
